// File: rtl/user_key_ctrl.sv
// Debounced active-low key bank with STATE/PEND(W1C)/MASK registers and a level IRQ; optional release events under USER_KEY_RELEASE_EN.
// Latency: key edge to STATE/PEND is 1+DEBOUNCE_CYCLES edges; RD is combinational, register writes land on the WE edge.
// Backpressure: none, the bus never stalls and every access completes in its own cycle.
module user_key_ctrl #(
    parameter int KEY_NUM         = 8,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_NUM-1:0] user_key,
    input  logic [3:0]         Addr,
    input  logic               WE,
    input  logic [31:0]        WD,
    output logic [31:0]        RD,
    output logic               IRQ
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [KEY_NUM-1:0] sync1_q, sync2_q;
    logic [KEY_NUM-1:0] stable_q, stable_d;
    logic [CW-1:0]      cnt_q [KEY_NUM];
    logic [CW-1:0]      cnt_d [KEY_NUM];
    logic [KEY_NUM-1:0] pend_q, pend_d;
    logic [KEY_NUM-1:0] mask_q, mask_d;
    logic [KEY_NUM-1:0] rise, fall;
    logic [KEY_NUM-1:0] irq_src;
    logic [1:0]         sel;
    logic               unused_bus;

    assign sel        = Addr[3:2];
    assign unused_bus = ^{Addr[1:0], WD};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < KEY_NUM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
    end

    // Set is OR-ed in after the clear so a same-cycle event beats a W1C write.
    always_comb begin
        pend_d = pend_q;
        mask_d = mask_q;
        if (WE && sel == 2'd1) pend_d = pend_q & ~WD[KEY_NUM-1:0];
        if (WE && sel == 2'd2) mask_d = WD[KEY_NUM-1:0];
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            for (int i = 0; i < KEY_NUM; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= ~user_key;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            for (int i = 0; i < KEY_NUM; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef USER_KEY_RELEASE_EN
    logic [KEY_NUM-1:0] rpend_q, rpend_d;

    always_comb begin
        rpend_d = rpend_q;
        if (WE && sel == 2'd3) rpend_d = rpend_q & ~WD[KEY_NUM-1:0];
        rpend_d = rpend_d | fall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rpend_q <= '0;
        else        rpend_q <= rpend_d;
    end

    assign irq_src = (pend_q | rpend_q) & mask_q;
`else
    logic unused_fall;
    assign unused_fall = ^fall;
    assign irq_src     = pend_q & mask_q;
`endif

    assign IRQ = |irq_src;

    always_comb begin
        RD = '0;
        case (sel)
            2'd0: RD = 32'(stable_q);
            2'd1: RD = 32'(pend_q);
            2'd2: RD = 32'(mask_q);
`ifdef USER_KEY_RELEASE_EN
            2'd3: RD = 32'(rpend_q);
`endif
            default: RD = '0;
        endcase
    end

endmodule

// File: tb/tb_user_key_ctrl.sv
// Directed bench for user_key_ctrl with KEY_NUM=8, DEBOUNCE_CYCLES=4.
module tb_user_key_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  user_key;
    logic [3:0]  Addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    user_key_ctrl #(.KEY_NUM(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .user_key(user_key), .Addr(Addr),
        .WE(WE), .WD(WD), .RD(RD), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, RD, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        #1;
        check(tag, {31'b0, IRQ}, {31'b0, exp});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        Addr = a;
        WD   = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        WD   = '0;
    endtask

    initial begin
        logic [12:0] bounce;
        reset = 1'b0; user_key = 8'hFF; Addr = '0; WE = 1'b0; WD = '0;

        // Reset state
        tick(3);
        chk_reg("rst_state", 4'h0, 32'h0);
        chk_reg("rst_pend",  4'h4, 32'h0);
        chk_reg("rst_mask",  4'h8, 32'h0);
        chk_reg("rst_reg3",  4'hC, 32'h0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b1;
        tick(10);
        chk_reg("idle_state", 4'h0, 32'h0);

        // Clean press of key0, masked in
        wr(4'h8, 32'h1);
        chk_reg("mask_rb", 4'h8, 32'h1);
        user_key = 8'hFE;
        tick(5);
        chk_reg("press_state_e4", 4'h0, 32'h0);
        chk_reg("press_pend_e4",  4'h4, 32'h0);
        chk_irq("press_irq_e4", 1'b0);
        tick();
        chk_reg("press_state_e5", 4'h0, 32'h1);
        chk_reg("press_pend_e5",  4'h4, 32'h1);
        chk_irq("press_irq_e5", 1'b1);
        wr(4'h4, 32'h1);
        chk_reg("press_clr", 4'h4, 32'h0);
        chk_irq("press_clr_irq", 1'b0);

        // Bounce on key3: low 3, high 1, low 2, then high
        bounce = 13'b1111111001000;
        for (int c = 0; c < 13; c++) begin
            user_key = {4'hF, bounce[c], 3'b110};
            tick();
            chk_reg("bounce_state", 4'h0, 32'h1);
            chk_reg("bounce_pend",  4'h4, 32'h0);
        end

        // W1C: build PEND=3, clear bit0
        user_key = 8'hFF;
        tick(10);
        chk_reg("rel0_state", 4'h0, 32'h0);
        user_key = 8'hFC;
        tick(6);
        chk_reg("w1c_pend3", 4'h4, 32'h3);
        wr(4'h4, 32'h1);
        chk_reg("w1c_pend2", 4'h4, 32'h2);

        // Set wins: clear bit1 on the same edge key1 re-presses
        user_key = 8'hFE;
        tick(10);
        wr(4'h4, 32'h2);
        chk_reg("w1c_pend0", 4'h4, 32'h0);
        user_key = 8'hFC;
        tick(5);
        chk_reg("setwin_pre", 4'h4, 32'h0);
        wr(4'h4, 32'h2);
        chk_reg("setwin_pend", 4'h4, 32'h2);
        chk_reg("setwin_state", 4'h0, 32'h3);

        // Mask
`ifdef USER_KEY_RELEASE_EN
        wr(4'hC, 32'hFF);
`endif
        user_key = 8'hF8;
        tick(6);
        wr(4'h4, 32'h2);
        chk_reg("mask_pend4", 4'h4, 32'h4);
        wr(4'h8, 32'h0);
        chk_irq("mask_off_irq", 1'b0);
        wr(4'h8, 32'h4);
        chk_irq("mask_on_irq", 1'b1);
        chk_reg("mask_pend_kept", 4'h4, 32'h4);
        wr(4'h4, 32'h4);
        chk_irq("mask_clr_irq", 1'b0);
        chk_reg("mask_pend_clr", 4'h4, 32'h0);

        // Release of key7
        user_key = 8'h78;
        tick(6);
        chk_reg("k7_pend", 4'h4, 32'h80);
        wr(4'h4, 32'h80);
        wr(4'h8, 32'h80);
`ifdef USER_KEY_RELEASE_EN
        wr(4'hC, 32'hFF);
`endif
        chk_irq("k7_irq_idle", 1'b0);
        user_key = 8'hF8;
        tick(5);
        chk_reg("rel_reg3_e4", 4'hC, 32'h0);
        tick();
        chk_reg("rel_state", 4'h0, 32'h07);
        chk_reg("rel_pend",  4'h4, 32'h0);
`ifdef USER_KEY_RELEASE_EN
        chk_reg("rel_rpend", 4'hC, 32'h80);
        chk_irq("rel_irq", 1'b1);
        wr(4'hC, 32'h80);
        chk_reg("rel_rpend_clr", 4'hC, 32'h0);
        chk_irq("rel_irq_clr", 1'b0);
`else
        chk_reg("rel_reg3", 4'hC, 32'h0);
        chk_irq("rel_irq", 1'b0);
        wr(4'hC, 32'hFF);
        chk_reg("rel_reg3_wr", 4'hC, 32'h0);
`endif

        // Reset mid-debounce discards the count and clears everything
        user_key = 8'hE8;
        tick(3);
        reset = 1'b0;
        #1;
        chk_reg("mid_rst_state", 4'h0, 32'h0);
        chk_reg("mid_rst_pend",  4'h4, 32'h0);
        chk_reg("mid_rst_mask",  4'h8, 32'h0);
        chk_irq("mid_rst_irq", 1'b0);
        tick(2);
        chk_reg("mid_rst_state2", 4'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/user_key_ctrl.md
# user_key_ctrl

Parametrised, debounced user-key peripheral on the CPU system bus. Samples `KEY_NUM` active-low push-buttons, synchronises and debounces each one, latches press events into a write-1-to-clear pending register, and raises a maskable interrupt. It is the bus-mapped, interrupt-capable generation of the plain key input device.

## Interface

- `KEY_NUM`, 8: number of keys, legal range 1..32.
- `DEBOUNCE_CYCLES`, 20000: consecutive stable cycles required to accept a new key level, legal range 2..2^20.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `user_key`  in  KEY_NUM  raw button inputs, active-low (0 = pressed), asynchronous to `clk`.
- `Addr`  in  4  byte address inside the device; bits [3:2] select the register, bits [1:0] are ignored.
- `WE`  in  1  bus write enable.
- `WD`  in  32  bus write data.
- `RD`  out  32  bus read data, combinational from `Addr`.
- `IRQ`  out  1  level interrupt request.

## Operation

- Input path per key: invert to active-high, then 2-flop synchroniser (`sync1`, `sync2`), then debouncer holding `stable` and counter `cnt` (width `$clog2(DEBOUNCE_CYCLES)`).
- Debouncer, each cycle:
  - If `sync2 == stable`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= sync2` and `cnt <= 0`.
  - Else `cnt <= cnt+1`.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
- Press event: the cycle in which `stable` goes 0→1 sets `PEND[i]`.
- Register map (`Addr[3:2]`):
  - 0: `STATE`, RO. Reads `{zero-extend, stable}`.
  - 1: `PEND`, W1C. A write clears every bit set in `WD[KEY_NUM-1:0]`.
  - 2: `MASK`, RW. Holds `WD[KEY_NUM-1:0]`.
  - 3: `RPEND` when `USER_KEY_RELEASE_EN` is defined; otherwise reads 0 and writes are ignored.
- Bits `[31:KEY_NUM]` of every register read 0. Writes to RO bits are ignored.
- `IRQ = |(PEND & MASK) | |(RPEND & MASK)`. The `RPEND` term exists only with the macro.
- If a W1C write and a new event on the same bit occur in the same cycle, set wins and the bit stays 1.
- A `MASK` write does not alter `PEND`. Unmasking a pending bit asserts `IRQ` immediately.

## Timing

- Reset (async assert, released synchronously by the system): `sync1`, `sync2`, `stable`, `cnt`, `PEND`, `RPEND`, `MASK` all go to 0. `IRQ` = 0. `RD` = 0 for every address.
- Keys held pressed through reset release are treated as a 0→1 transition and generate a press event after debounce. This is intended.
- Latency:
  - A clean level change on `user_key` that is set up before edge E updates `stable`, and sets `PEND`/`RPEND`, at edge E+1+`DEBOUNCE_CYCLES`.
  - `IRQ` (if masked in) is high after that same edge.
- Register writes take effect at the clock edge where `WE` = 1. `RD` and `IRQ` reflect the new value after that edge.
- `RD` has zero-cycle latency (combinational). No wait states.
- Reset asserted mid-debounce discards the count. No event is produced.

## Configuration

- `USER_KEY_RELEASE_EN` defined:
  - Release detection is compiled in. `stable` going 1→0 sets `RPEND[i]`.
  - `RPEND` is W1C at register 3, with the same set-wins rule as `PEND`.
  - `MASK` gates `RPEND` into `IRQ`.
- `USER_KEY_RELEASE_EN` undefined:
  - No `RPEND` flops.
  - Register 3 reads 0.
  - Releases produce no event and no interrupt.

## Test plan

All scenarios use `KEY_NUM`=8 and `DEBOUNCE_CYCLES`=4.

- **Reset:** hold `reset`=0 with `user_key`=8'hFF. Read each address → `RD`=0 and `IRQ`=0. Release reset; after 10 cycles `STATE`=0.
- **Clean press:** drive `user_key`=8'hFE before edge E → `STATE`=32'h1 and `PEND`=32'h1 exactly at edge E+5, not at E+4. With `MASK`=1, `IRQ` rises at the same edge.
- **Bounce rejection:** toggle `user_key[3]` low for 3 cycles, high for 1, low for 2, then high → `STATE` and `PEND` stay 0 throughout.
- **W1C with set-wins:**
  - Set `PEND`=8'h03, then write 32'h1 to register 1 → `PEND`=8'h02.
  - Write 32'h2 in the same cycle that key1 presses again → `PEND[1]` remains 1.
- **Mask:** with `PEND`=8'h04 and `MASK`=0, `IRQ`=0. Write `MASK`=32'h4 → `IRQ`=1 next cycle. Write 32'h4 to `PEND` → `IRQ`=0.
- **Release (macro defined):** press then release key7 → `RPEND`=32'h80 at edge E+5 after release. Without the macro, register 3 reads 0 and `IRQ` does not assert on release.
